gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
Self-checking stimulus/response stage for the mux-built logic-gate block (two inputs a, b; seven outputs AND, OR, NOT, NAND, NOR, XOR, XNOR).
- Drives all four (a,b) input vectors into the gate block.
- Waits a programmable settle time, then compares the seven outputs against a golden truth table.
- Reports error count, first-failure information and a pass flag.
- Sits directly upstream (feeds a, b) and downstream (consumes outputs) of the gate block, replacing hand-stepped bench stimulus with hardware sequencing usable on-board.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after each vector is applied before sampling; legal range ≥1.
- LOOPS, 1, number of full passes over the 4 vectors; legal range ≥1.
- ERR_W, 4, width of the error counter; counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a run.
- a  output  1  gate-block input a (registered).
- b  output  1  gate-block input b (registered).
- y_in  input  7  gate-block outputs. Bit map: 0 and, 1 or, 2 not (= ~a), 3 nand, 4 nor, 5 xor, 6 xnor.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until next accepted start or rst.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  ERR_W  number of failing vector checks, saturating.
- fail_vec  output  2  {a,b} index of the first failing check.
- fail_mask  output  7  y_in ^ expected at the first failing check; 0 if no failure.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0; state IDLE; vec_idx, loop_cnt and settle_cnt all 0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE / DONE:
  - start=1 → SETTLE next cycle.
  - Same edge: vec_idx←0, loop_cnt←0, settle_cnt←0, {a,b}←2'b00, err_count←0, fail_vec←0, fail_mask←0, done←0, busy←1.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1 → CHECK.
  - The state occupies exactly SETTLE_CYCLES cycles per vector.
- CHECK (one cycle):
  - Compare y_in to expected({a,b}).
  - On mismatch: err_count+1, saturating at all-ones.
  - If this is the first mismatch of the run (err_count==0 before the increment), capture fail_vec←{a,b} and fail_mask←y_in^expected.
  - If vec_idx==3 and loop_cnt==LOOPS-1 → DONE: busy←0, done←1.
  - Otherwise: vec_idx+1 (wraps 3→0; loop_cnt+1 on wrap), {a,b}←next vec_idx, settle_cnt←0 → SETTLE.
- Vector order: 00, 01, 10, 11, with a = vec_idx[1] and b = vec_idx[0].
- Expected values (per {a,b}):
  - and = a&b, or = a|b, not = ~a, nand = ~(a&b), nor = ~(a|b), xor = a^b, xnor = ~(a^b).
- Timing:
  - A start seen at cycle 0 puts vector 0 on a,b at cycle 1.
  - Each vector lasts SETTLE_CYCLES+1 cycles.
  - done rises at cycle 4·LOOPS·(SETTLE_CYCLES+1)+1.
- Outputs a, b hold the last vector in DONE.
- start while busy=1 is ignored; it has no effect on counters or state.
- start in DONE restarts the run and clears all results on the same edge.
- rst mid-run: next cycle back to IDLE with reset values; results are discarded.
- y_in is sampled only in CHECK; activity in other states is ignored.

Decomposition:
- Package gate_chk_pkg holds:
  - state encoding constants;
  - output bit-index constants (IDX_AND..IDX_XNOR);
  - NUM_GATES=7.
- One sub-module: gate_ref_model, purely combinational, inputs a, b → 7-bit expected vector in package bit order. It is instantiated once in the checker.

Test Plan:
- Ideal gate model, defaults (S=2, L=1): start at cycle 0 → a,b step 00/01/10/11 every 3 cycles; done=1 at cycle 13; pass=1, err_count=0, fail_mask=0.
- xor output stuck-at-0: vectors 01 and 10 fail → err_count=2, fail_vec=2'b01, fail_mask=7'b0100000, pass=0.
- All outputs stuck-at-0, LOOPS=2, ERR_W=3: all 8 checks fail → err_count saturates at 7; fail_vec=0, fail_mask=7'b1011100.
- start pulsed at cycles 0 and 5, ideal model: second pulse ignored; done still at cycle 13, err_count=0.
- rst asserted at cycle 7 during a run with a faulty model: cycle 8 shows IDLE, busy=0, done=0, err_count=0, a=b=0. A new start then gives a full clean run.
- After a pass run, start again with xnor stuck-at-1: done cleared on the start edge, rises again at +13 cycles; err_count=2, fail_vec=2'b01, fail_mask=7'b1000000.

Source files
------------

// File: rtl/gate_vector_checker_pkg.sv
// Shared definitions for the gate-block vector checker: FSM encoding and the
// bit positions of the seven gate outputs on y_in.
package gate_chk_pkg;

    localparam int NUM_GATES = 7;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_NOT  = 2;
    localparam int IDX_NAND = 3;
    localparam int IDX_NOR  = 4;
    localparam int IDX_XOR  = 5;
    localparam int IDX_XNOR = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gate_vector_checker_if.sv
// Stimulus/response bundle between the checker (master) and its host plus the
// gate block under test (slave side).
interface gate_vector_checker_if
    import gate_chk_pkg::*;
#(
    parameter int ERR_W = 4
);
    logic                 start;
    logic                 a;
    logic                 b;
    logic [NUM_GATES-1:0] y_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_count;
    logic [1:0]           fail_vec;
    logic [NUM_GATES-1:0] fail_mask;

    modport master (
        input  start, y_in,
        output a, b, busy, done, pass, err_count, fail_vec, fail_mask
    );

    modport slave (
        output start, y_in,
        input  a, b, busy, done, pass, err_count, fail_vec, fail_mask
    );
endinterface

// File: rtl/gate_vector_checker_ref.sv
// Golden truth table of the gate block, purely combinational, in the bit
// order defined by gate_chk_pkg.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] y
);
    always_comb begin
        y           = '0;
        y[IDX_AND]  = a & b;
        y[IDX_OR]   = a | b;
        y[IDX_NOT]  = ~a;
        y[IDX_NAND] = ~(a & b);
        y[IDX_NOR]  = ~(a | b);
        y[IDX_XOR]  = a ^ b;
        y[IDX_XNOR] = ~(a ^ b);
    end
endmodule

// File: rtl/gate_vector_checker.sv
// Sequences the four (a,b) vectors into the gate block, waits a settle time,
// and grades the seven outputs against the reference truth table.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 4
) (
    input logic                   clk,
    input logic                   rst,
    gate_vector_checker_if.master bus
);
    localparam int SET_W  = $clog2(SETTLE_CYCLES) + 1;
    localparam int LOOP_W = $clog2(LOOPS) + 1;

    state_t               state;
    logic [1:0]           vec_idx;
    logic [LOOP_W-1:0]    loop_cnt;
    logic [SET_W-1:0]     settle_cnt;
    logic                 a_r;
    logic                 b_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 pass_r;
    logic [ERR_W-1:0]     err_r;
    logic [1:0]           fail_vec_r;
    logic [NUM_GATES-1:0] fail_mask_r;
    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] diff;
    logic                 mismatch;
    logic                 last_check;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    gate_ref_model u_ref (
        .a (a_r),
        .b (b_r),
        .y (expected)
    );

    assign diff       = bus.y_in ^ expected;
    assign mismatch   = |diff;
    assign last_check = (vec_idx == 2'd3) && (loop_cnt == LOOP_W'(LOOPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            vec_idx     <= '0;
            loop_cnt    <= '0;
            settle_cnt  <= '0;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_r       <= '0;
            fail_vec_r  <= '0;
            fail_mask_r <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // A restart from DONE discards the previous run's results.
                    if (bus.start) begin
                        state       <= ST_SETTLE;
                        vec_idx     <= '0;
                        loop_cnt    <= '0;
                        settle_cnt  <= '0;
                        a_r         <= 1'b0;
                        b_r         <= 1'b0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        err_r       <= '0;
                        fail_vec_r  <= '0;
                        fail_mask_r <= '0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    if (settle_cnt == SET_W'(SETTLE_CYCLES - 1))
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_r <= sat_inc(err_r);
                        if (err_r == '0) begin
                            fail_vec_r  <= {a_r, b_r};
                            fail_mask_r <= diff;
                        end
                    end
                    if (last_check) begin
                        state  <= ST_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= !mismatch && (err_r == '0);
                    end else begin
                        // vec_idx wraps 3->0 naturally; a wrap starts the next loop.
                        vec_idx    <= vec_idx + 2'd1;
                        {a_r, b_r} <= vec_idx + 2'd1;
                        if (vec_idx == 2'd3)
                            loop_cnt <= loop_cnt + LOOP_W'(1);
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.a         = a_r;
    assign bus.b         = b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.fail_vec  = fail_vec_r;
    assign bus.fail_mask = fail_mask_r;
endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: two checker instances (default and LOOPS=2/ERR_W=3) driving a
// behavioural gate block with injectable stuck-at faults.
module tb_gate_vector_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] sa0_0 = '0, sa1_0 = '0, sa0_1 = '0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    gate_vector_checker_if #(.ERR_W(4)) bus0 ();
    gate_vector_checker_if #(.ERR_W(3)) bus1 ();

    gate_vector_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    gate_vector_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(3)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    // Behavioural gate block: bit 6..0 = xnor, xor, nor, nand, not, or, and
    function automatic logic [6:0] gate_block(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    assign bus0.y_in = (gate_block(bus0.a, bus0.b) & ~sa0_0) | sa1_0;
    assign bus1.y_in = (gate_block(bus1.a, bus1.b) & ~sa0_1);

    // Pulse start on dut0 and follow the run until done; start edge is cycle 0.
    task automatic run0(input int start2_cyc, output int done_cyc, output int seq_err,
                        output logic done1);
        int cyc;
        @(posedge clk); #1 bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        cyc = 1; seq_err = 0; done1 = bus0.done;
        while ((bus0.done !== 1'b1 || cyc == 1) && cyc < 100) begin
            if (cyc <= 12 && ({bus0.a, bus0.b} !== 2'((cyc - 1) / 3) || bus0.busy !== 1'b1))
                seq_err++;
            bus0.start = (cyc == start2_cyc);
            @(posedge clk); #1;
            cyc++;
        end
        bus0.start = 1'b0;
        done_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus0.start = 1'b0; bus1.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if ({bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass}); end
        checks++; if (bus0.err_count !== 4'd0 || bus0.fail_vec !== 2'd0 || bus0.fail_mask !== 7'd0) begin errors++; $display("FAIL reset_results: err=%0d vec=%0d mask=%b expected 0", bus0.err_count, bus0.fail_vec, bus0.fail_mask); end
        checks++; if ({bus1.busy, bus1.done, bus1.err_count} !== 5'b0) begin errors++; $display("FAIL reset_dut1: got %b expected 0", {bus1.busy, bus1.done, bus1.err_count}); end
    endtask

    task automatic test_ideal();
        int dc, se; logic d1;
        run0(-1, dc, se, d1);
        checks++; if (dc != 13) begin errors++; $display("FAIL ideal_done_cycle: got %0d expected 13", dc); end
        checks++; if (se != 0) begin errors++; $display("FAIL ideal_sequence: got %0d bad cycles expected 0", se); end
        checks++; if (bus0.pass !== 1'b1 || bus0.err_count !== 4'd0 || bus0.fail_mask !== 7'd0) begin errors++; $display("FAIL ideal_result: pass=%b err=%0d mask=%b expected 1/0/0", bus0.pass, bus0.err_count, bus0.fail_mask); end
        repeat (3) @(posedge clk); #1;
        checks++; if ({bus0.a, bus0.b, bus0.busy, bus0.done} !== 4'b1101) begin errors++; $display("FAIL ideal_hold: got %b expected 1101", {bus0.a, bus0.b, bus0.busy, bus0.done}); end
    endtask

    task automatic test_xor_sa0();
        int dc, se; logic d1;
        sa0_0 = 7'b0100000;
        run0(-1, dc, se, d1);
        sa0_0 = '0;
        checks++; if (dc != 13) begin errors++; $display("FAIL xor_done_cycle: got %0d expected 13", dc); end
        checks++; if (bus0.err_count !== 4'd2) begin errors++; $display("FAIL xor_err_count: got %0d expected 2", bus0.err_count); end
        checks++; if (bus0.fail_vec !== 2'b01 || bus0.fail_mask !== 7'b0100000) begin errors++; $display("FAIL xor_first_fail: vec=%b mask=%b expected 01/0100000", bus0.fail_vec, bus0.fail_mask); end
        checks++; if (bus0.pass !== 1'b0) begin errors++; $display("FAIL xor_pass: got %b expected 0", bus0.pass); end
    endtask

    task automatic test_saturate();
        int cyc;
        sa0_1 = 7'h7f;
        @(posedge clk); #1 bus1.start = 1'b1;
        @(posedge clk); #1 bus1.start = 1'b0;
        cyc = 1;
        while (bus1.done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc != 25) begin errors++; $display("FAIL sat_done_cycle: got %0d expected 25", cyc); end
        checks++; if (bus1.err_count !== 3'd7) begin errors++; $display("FAIL sat_err_count: got %0d expected 7", bus1.err_count); end
        checks++; if (bus1.fail_vec !== 2'b00 || bus1.fail_mask !== 7'b1011100) begin errors++; $display("FAIL sat_first_fail: vec=%b mask=%b expected 00/1011100", bus1.fail_vec, bus1.fail_mask); end
        checks++; if (bus1.pass !== 1'b0 || {bus1.a, bus1.b} !== 2'b11) begin errors++; $display("FAIL sat_pass_ab: pass=%b ab=%b expected 0/11", bus1.pass, {bus1.a, bus1.b}); end
    endtask

    task automatic test_start_ignored();
        int dc, se; logic d1;
        run0(5, dc, se, d1);
        checks++; if (dc != 13) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 13", dc); end
        checks++; if (se != 0 || bus0.err_count !== 4'd0 || bus0.pass !== 1'b1) begin errors++; $display("FAIL busy_start_result: seq=%0d err=%0d pass=%b expected 0/0/1", se, bus0.err_count, bus0.pass); end
    endtask

    task automatic test_rst_mid_run();
        int dc, se; logic d1;
        sa0_0 = 7'h7f;
        @(posedge clk); #1 bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (bus0.err_count !== 4'd2 || bus0.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_state: err=%0d busy=%b expected 2/1", bus0.err_count, bus0.busy); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++; if ({bus0.busy, bus0.done, bus0.pass, bus0.a, bus0.b} !== 5'b0 || bus0.err_count !== 4'd0) begin errors++; $display("FAIL rst_cleared: ctrl=%b err=%0d expected 0", {bus0.busy, bus0.done, bus0.pass, bus0.a, bus0.b}, bus0.err_count); end
        checks++; if (bus0.fail_mask !== 7'd0) begin errors++; $display("FAIL rst_fail_mask: got %b expected 0", bus0.fail_mask); end
        repeat (4) @(posedge clk); #1;
        checks++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: busy=%b done=%b expected 0/0", bus0.busy, bus0.done); end
        sa0_0 = '0;
        run0(-1, dc, se, d1);
        checks++; if (dc != 13 || se != 0 || bus0.pass !== 1'b1 || bus0.err_count !== 4'd0) begin errors++; $display("FAIL rst_rerun: cyc=%0d seq=%0d pass=%b err=%0d expected 13/0/1/0", dc, se, bus0.pass, bus0.err_count); end
    endtask

    task automatic test_restart();
        int dc, se; logic d1;
        checks++; if (bus0.done !== 1'b1 || bus0.pass !== 1'b1) begin errors++; $display("FAIL restart_precond: done=%b pass=%b expected 1/1", bus0.done, bus0.pass); end
        sa1_0 = 7'b1000000;
        run0(-1, dc, se, d1);
        sa1_0 = '0;
        checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL restart_done_clear: got %b expected 0", d1); end
        checks++; if (dc != 13 || se != 0) begin errors++; $display("FAIL restart_timing: cyc=%0d seq=%0d expected 13/0", dc, se); end
        checks++; if (bus0.err_count !== 4'd2 || bus0.pass !== 1'b0) begin errors++; $display("FAIL restart_err: err=%0d pass=%b expected 2/0", bus0.err_count, bus0.pass); end
        checks++; if (bus0.fail_vec !== 2'b01 || bus0.fail_mask !== 7'b1000000) begin errors++; $display("FAIL restart_first_fail: vec=%b mask=%b expected 01/1000000", bus0.fail_vec, bus0.fail_mask); end
    endtask

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        test_reset();
        test_ideal();
        test_xor_sa0();
        test_saturate();
        test_start_ignored();
        test_rst_mid_run();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
